// File: rtl/stage_mem_pkg.sv
// stage_mem_pkg -- shared types and constants for the memory/commit stage.
//
// Contents:
//   WD_SIZE, INSTR_SIZE, INSTR_REG_BITS, BE_BITS : datapath widths
//   mem_state_t                                  : memory-stage FSM states
//   FUNCT3_*                                     : load/store size/sign encodings
//   mem_be_gen / mem_wdata_gen / mem_misaligned  : request-forming helpers
//
// Optional feature macro used by the stage: MEM_MISALIGN_TRAP_EN.
package stage_mem_pkg;

  localparam int WD_SIZE        = 32;
  localparam int INSTR_SIZE     = 32;
  localparam int INSTR_REG_BITS = 5;
  localparam int BE_BITS        = WD_SIZE / 8;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_t;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // Byte enables from access size (funct3[1:0]) and the low address bits.
  // Sizes other than byte/half fall back to a full word.
  function automatic logic [BE_BITS-1:0] mem_be_gen(input logic [2:0] f3,
                                                    input logic [1:0] a);
    logic [BE_BITS-1:0] be;
    case (f3[1:0])
      FUNCT3_SB[1:0]: be = BE_BITS'(1) << a;
      FUNCT3_SH[1:0]: be = BE_BITS'(3) << {a[1], 1'b0};
      default:        be = {BE_BITS{1'b1}};
    endcase
    return be;
  endfunction

  // Store data replicated across every lane so the byte enables alone
  // decide which bytes land in memory.
  function automatic logic [WD_SIZE-1:0] mem_wdata_gen(input logic [2:0]         f3,
                                                       input logic [WD_SIZE-1:0] d);
    logic [WD_SIZE-1:0] w;
    case (f3[1:0])
      FUNCT3_SB[1:0]: w = {(WD_SIZE/8){d[7:0]}};
      FUNCT3_SH[1:0]: w = {(WD_SIZE/16){d[15:0]}};
      default:        w = d;
    endcase
    return w;
  endfunction

  // Half needs a[0]==0; word (and any undefined size) needs a[1:0]==0.
  function automatic logic mem_misaligned(input logic [2:0] f3,
                                          input logic [1:0] a);
    logic m;
    case (f3[1:0])
      FUNCT3_SB[1:0]: m = 1'b0;
      FUNCT3_SH[1:0]: m = a[0];
      default:        m = (a != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/stage_mem_load_align.sv
// stage_mem_load_align -- combinational load lane select and extension.
//
// Ports:
//   rdata_i    [WD_SIZE-1:0]  raw word returned by data memory
//   addr_lo_i  [1:0]          low address bits of the load
//   funct3_i   [2:0]          access size/sign
//   data_o     [WD_SIZE-1:0]  extended value for writeback
//
// Undefined funct3 encodings return the whole word.
module stage_mem_load_align
  import stage_mem_pkg::*;
(
  input  logic [WD_SIZE-1:0] rdata_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [2:0]         funct3_i,
  output logic [WD_SIZE-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
    // Halves are picked by a[1] only; a[0] is ignored for unaligned halves.
    half_v = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (funct3_i)
      FUNCT3_LB:  data_o = {{(WD_SIZE-8){byte_v[7]}}, byte_v};
      FUNCT3_LH:  data_o = {{(WD_SIZE-16){half_v[15]}}, half_v};
      FUNCT3_LBU: data_o = {{(WD_SIZE-8){1'b0}}, byte_v};
      FUNCT3_LHU: data_o = {{(WD_SIZE-16){1'b0}}, half_v};
      default:    data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// stage_mem -- memory/commit stage of the in-order pipeline.
//
// Consumes the ALU stage outputs, issues data-memory requests for loads and
// stores (stalling upstream while busy), resolves branch/jump redirects and
// delivers results to writeback.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   in_valid, stall_o            upstream handshake (in_valid sampled in IDLE only)
//   pc_i, rd_i, instr_*_i        target PC, destination reg, one-hot class flags
//   funct3_i                     access size/sign
//   alu_result_i, alu_zero_i     address/result, branch condition
//   rs2_data_i                   store data
//   mem_req_*                    valid/ready data-memory request
//   mem_rsp_valid_i/rdata_i      load response
//   wb_*                         writeback pulse, enable, register, data
//   redirect_valid_o/pc_o        fetch redirect pulse and target
//
// Macro MEM_MISALIGN_TRAP_EN: when defined, misaligned half/word accesses
// issue no request and instead pulse misalign_o with misalign_addr_o.
// When undefined those ports are absent and low address bits are ignored.
module stage_mem
  import stage_mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      stall_o,
  input  logic [INSTR_SIZE-1:0]     pc_i,
  input  logic [INSTR_REG_BITS-1:0] rd_i,
  input  logic                      instr_op_i,
  input  logic                      instr_ld_i,
  input  logic                      instr_st_i,
  input  logic                      instr_jm_i,
  input  logic                      instr_br_i,
  input  logic [2:0]                funct3_i,
  input  logic [WD_SIZE-1:0]        alu_result_i,
  input  logic                      alu_zero_i,
  input  logic [WD_SIZE-1:0]        rs2_data_i,
  output logic                      mem_req_valid_o,
  input  logic                      mem_req_ready_i,
  output logic                      mem_req_we_o,
  output logic [WD_SIZE-1:0]        mem_req_addr_o,
  output logic [WD_SIZE-1:0]        mem_req_wdata_o,
  output logic [BE_BITS-1:0]        mem_req_be_o,
  input  logic                      mem_rsp_valid_i,
  input  logic [WD_SIZE-1:0]        mem_rsp_rdata_i,
  output logic                      wb_valid_o,
  output logic                      wb_we_o,
  output logic [INSTR_REG_BITS-1:0] wb_rd_o,
  output logic [WD_SIZE-1:0]        wb_data_o,
  output logic                      redirect_valid_o,
  output logic [INSTR_SIZE-1:0]     redirect_pc_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                      misalign_o,
  output logic [WD_SIZE-1:0]        misalign_addr_o
`endif
);

  mem_state_t                state_q;
  logic                      is_load_q;
  logic [2:0]                funct3_q;
  logic [1:0]                addr_lo_q;
  logic [INSTR_REG_BITS-1:0] rd_q;

  logic                      req_valid_q;
  logic                      req_we_q;
  logic [WD_SIZE-1:0]        req_addr_q;
  logic [WD_SIZE-1:0]        req_wdata_q;
  logic [BE_BITS-1:0]        req_be_q;

  logic                      wb_valid_q;
  logic                      wb_we_q;
  logic [INSTR_REG_BITS-1:0] wb_rd_q;
  logic [WD_SIZE-1:0]        wb_data_q;
  logic                      redirect_valid_q;
  logic [INSTR_SIZE-1:0]     redirect_pc_q;

`ifdef MEM_MISALIGN_TRAP_EN
  logic                      misalign_q;
  logic [WD_SIZE-1:0]        misalign_addr_q;
`endif

  logic [WD_SIZE-1:0]        load_data_d;

  stage_mem_load_align u_load_align (
    .rdata_i   (mem_rsp_rdata_i),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .data_o    (load_data_d)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= MEM_IDLE;
      is_load_q        <= 1'b0;
      funct3_q         <= '0;
      addr_lo_q        <= '0;
      rd_q             <= '0;
      req_valid_q      <= 1'b0;
      req_we_q         <= 1'b0;
      req_addr_q       <= '0;
      req_wdata_q      <= '0;
      req_be_q         <= '0;
      wb_valid_q       <= 1'b0;
      wb_we_q          <= 1'b0;
      wb_rd_q          <= '0;
      wb_data_q        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q       <= 1'b0;
      misalign_addr_q  <= '0;
`endif
    end else begin
      // Pulse outputs are high for exactly one cycle.
      wb_valid_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q       <= 1'b0;
`endif
      case (state_q)
        MEM_IDLE: begin
          if (in_valid) begin
            if (instr_ld_i || instr_st_i) begin
`ifdef MEM_MISALIGN_TRAP_EN
              if (mem_misaligned(funct3_i, alu_result_i[1:0])) begin
                wb_valid_q      <= 1'b1;
                wb_we_q         <= 1'b0;
                wb_rd_q         <= rd_i;
                wb_data_q       <= '0;
                misalign_q      <= 1'b1;
                misalign_addr_q <= alu_result_i;
              end else
`endif
              begin
                state_q     <= MEM_REQ;
                is_load_q   <= instr_ld_i;
                funct3_q    <= funct3_i;
                addr_lo_q   <= alu_result_i[1:0];
                rd_q        <= rd_i;
                req_valid_q <= 1'b1;
                req_we_q    <= instr_st_i;
                req_addr_q  <= {alu_result_i[WD_SIZE-1:2], 2'b00};
                req_wdata_q <= mem_wdata_gen(funct3_i, rs2_data_i);
                req_be_q    <= mem_be_gen(funct3_i, alu_result_i[1:0]);
              end
            end else if (instr_br_i) begin
              wb_valid_q       <= 1'b1;
              wb_we_q          <= 1'b0;
              wb_rd_q          <= rd_i;
              wb_data_q        <= alu_result_i;
              redirect_valid_q <= alu_zero_i;
              redirect_pc_q    <= pc_i;
            end else if (instr_op_i || instr_jm_i) begin
              wb_valid_q       <= 1'b1;
              wb_we_q          <= (rd_i != '0);
              wb_rd_q          <= rd_i;
              wb_data_q        <= alu_result_i;
              redirect_valid_q <= instr_jm_i;
              redirect_pc_q    <= pc_i;
            end
          end
        end

        // A response seen here is a protocol violation and is dropped.
        MEM_REQ: begin
          if (mem_req_ready_i) begin
            req_valid_q <= 1'b0;
            if (is_load_q) begin
              state_q <= MEM_RESP;
            end else begin
              state_q    <= MEM_IDLE;
              wb_valid_q <= 1'b1;
              wb_we_q    <= 1'b0;
              wb_rd_q    <= rd_q;
              wb_data_q  <= '0;
            end
          end
        end

        MEM_RESP: begin
          if (mem_rsp_valid_i) begin
            state_q    <= MEM_IDLE;
            wb_valid_q <= 1'b1;
            wb_we_q    <= (rd_q != '0);
            wb_rd_q    <= rd_q;
            wb_data_q  <= load_data_d;
          end
        end

        default: state_q <= MEM_IDLE;
      endcase
    end
  end

  assign stall_o          = (state_q != MEM_IDLE);
  assign mem_req_valid_o  = req_valid_q;
  assign mem_req_we_o     = req_we_q;
  assign mem_req_addr_o   = req_addr_q;
  assign mem_req_wdata_o  = req_wdata_q;
  assign mem_req_be_o     = req_be_q;
  assign wb_valid_o       = wb_valid_q;
  assign wb_we_o          = wb_we_q;
  assign wb_rd_o          = wb_rd_q;
  assign wb_data_o        = wb_data_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_o       = misalign_q;
  assign misalign_addr_o  = misalign_addr_q;
`endif

endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem -- randomized self-checking bench for stage_mem.
// Expected values come from a size/offset arithmetic model of the stage's
// behaviour; the memory side is emulated with random ready/response delays.
module tb_stage_mem;
  import stage_mem_pkg::*;

  localparam int K_OP = 0, K_JM = 1, K_BR = 2, K_LD = 3, K_ST = 4;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      stall_o;
  logic [INSTR_SIZE-1:0]     pc_i = '0;
  logic [INSTR_REG_BITS-1:0] rd_i = '0;
  logic                      instr_op_i = 1'b0, instr_ld_i = 1'b0, instr_st_i = 1'b0;
  logic                      instr_jm_i = 1'b0, instr_br_i = 1'b0;
  logic [2:0]                funct3_i = '0;
  logic [WD_SIZE-1:0]        alu_result_i = '0;
  logic                      alu_zero_i = 1'b0;
  logic [WD_SIZE-1:0]        rs2_data_i = '0;
  logic                      mem_req_valid_o;
  logic                      mem_req_ready_i = 1'b0;
  logic                      mem_req_we_o;
  logic [WD_SIZE-1:0]        mem_req_addr_o;
  logic [WD_SIZE-1:0]        mem_req_wdata_o;
  logic [BE_BITS-1:0]        mem_req_be_o;
  logic                      mem_rsp_valid_i = 1'b0;
  logic [WD_SIZE-1:0]        mem_rsp_rdata_i = '0;
  logic                      wb_valid_o;
  logic                      wb_we_o;
  logic [INSTR_REG_BITS-1:0] wb_rd_o;
  logic [WD_SIZE-1:0]        wb_data_o;
  logic                      redirect_valid_o;
  logic [INSTR_SIZE-1:0]     redirect_pc_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                      misalign_o;
  logic [WD_SIZE-1:0]        misalign_addr_o;
`endif

  int tests = 0;
  int fails = 0;

  stage_mem dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .stall_o          (stall_o),
    .pc_i             (pc_i),
    .rd_i             (rd_i),
    .instr_op_i       (instr_op_i),
    .instr_ld_i       (instr_ld_i),
    .instr_st_i       (instr_st_i),
    .instr_jm_i       (instr_jm_i),
    .instr_br_i       (instr_br_i),
    .funct3_i         (funct3_i),
    .alu_result_i     (alu_result_i),
    .alu_zero_i       (alu_zero_i),
    .rs2_data_i       (rs2_data_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_we_o     (mem_req_we_o),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_wdata_o  (mem_req_wdata_o),
    .mem_req_be_o     (mem_req_be_o),
    .mem_rsp_valid_i  (mem_rsp_valid_i),
    .mem_rsp_rdata_i  (mem_rsp_rdata_i),
    .wb_valid_o       (wb_valid_o),
    .wb_we_o          (wb_we_o),
    .wb_rd_o          (wb_rd_o),
    .wb_data_o        (wb_data_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_o       (misalign_o),
    .misalign_addr_o  (misalign_addr_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model -------------------------------------------------
  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    if (sz == 1) return 32'd1 << (a % 4);
    if (sz == 2) return 32'd3 << (a & 32'd2);
    return 32'd15;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz = size_of(f3);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    int sz = size_of(f3);
    logic [31:0] v;
    if (sz == 1) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = (w >> (8 * (a & 32'd2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    int sz = size_of(f3);
    return (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // ---- one transaction ---------------------------------------------------
  task automatic run_txn(input int kind, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f3, input logic zero,
                         input logic [31:0] pc, input logic [31:0] rdata,
                         input int rdy_wait, input int rsp_wait);
    check("idle_stall", {31'd0, stall_o}, 32'd0);
    in_valid     = 1'b1;
    instr_op_i   = (kind == K_OP);
    instr_jm_i   = (kind == K_JM);
    instr_br_i   = (kind == K_BR);
    instr_ld_i   = (kind == K_LD);
    instr_st_i   = (kind == K_ST);
    rd_i         = rd;
    alu_result_i = a;
    rs2_data_i   = d;
    funct3_i     = f3;
    alu_zero_i   = zero;
    pc_i         = pc;
    tick();
    in_valid   = 1'b0;
    instr_op_i = 1'b0; instr_jm_i = 1'b0; instr_br_i = 1'b0;
    instr_ld_i = 1'b0; instr_st_i = 1'b0;
    alu_result_i = $urandom;

    if (kind == K_OP || kind == K_JM || kind == K_BR) begin
      check("alu_wb_valid", {31'd0, wb_valid_o}, 32'd1);
      check("alu_wb_we", {31'd0, wb_we_o}, (kind != K_BR && rd != 0) ? 32'd1 : 32'd0);
      check("alu_wb_rd", {27'd0, wb_rd_o}, {27'd0, rd});
      if (kind != K_BR) check("alu_wb_data", wb_data_o, a);
      check("redir_valid", {31'd0, redirect_valid_o},
            (kind == K_JM || (kind == K_BR && zero)) ? 32'd1 : 32'd0);
      if (kind == K_JM || (kind == K_BR && zero)) check("redir_pc", redirect_pc_o, pc);
      check("alu_stall", {31'd0, stall_o}, 32'd0);
      check("alu_no_req", {31'd0, mem_req_valid_o}, 32'd0);
      $display("[TB] kind=%0d rd=%0d a=0x%08h pc=0x%08h zero=%0b", kind, rd, a, pc, zero);
    end else if (model_misaligned(f3, a)) begin
`ifdef MEM_MISALIGN_TRAP_EN
      check("mis_wb_valid", {31'd0, wb_valid_o}, 32'd1);
      check("mis_wb_we", {31'd0, wb_we_o}, 32'd0);
      check("mis_flag", {31'd0, misalign_o}, 32'd1);
      check("mis_addr", misalign_addr_o, a);
      check("mis_no_req", {31'd0, mem_req_valid_o}, 32'd0);
      check("mis_stall", {31'd0, stall_o}, 32'd0);
`endif
      $display("[TB] kind=%0d misaligned f3=%0d a=0x%08h", kind, f3, a);
    end else begin
      check("req_valid", {31'd0, mem_req_valid_o}, 32'd1);
      check("req_stall", {31'd0, stall_o}, 32'd1);
      check("req_we", {31'd0, mem_req_we_o}, (kind == K_ST) ? 32'd1 : 32'd0);
      check("req_addr", mem_req_addr_o, a & 32'hFFFF_FFFC);
      check("req_be", {28'd0, mem_req_be_o}, exp_be(f3, a));
      if (kind == K_ST) check("req_wdata", mem_req_wdata_o, exp_wdata(f3, d));
      check("req_wb_quiet", {31'd0, wb_valid_o}, 32'd0);
      for (int i = 0; i < rdy_wait; i++) begin
        tick();
        check("req_hold_valid", {31'd0, mem_req_valid_o}, 32'd1);
        check("req_hold_addr", mem_req_addr_o, a & 32'hFFFF_FFFC);
      end
      mem_req_ready_i = 1'b1;
      tick();
      mem_req_ready_i = 1'b0;
      check("hs_req_drop", {31'd0, mem_req_valid_o}, 32'd0);
      if (kind == K_ST) begin
        check("st_wb_valid", {31'd0, wb_valid_o}, 32'd1);
        check("st_wb_we", {31'd0, wb_we_o}, 32'd0);
        check("st_stall", {31'd0, stall_o}, 32'd0);
      end else begin
        check("ld_wait_stall", {31'd0, stall_o}, 32'd1);
        check("ld_wait_wb", {31'd0, wb_valid_o}, 32'd0);
        for (int i = 0; i < rsp_wait; i++) begin
          tick();
          check("ld_resp_stall", {31'd0, stall_o}, 32'd1);
        end
        mem_rsp_valid_i = 1'b1;
        mem_rsp_rdata_i = rdata;
        tick();
        mem_rsp_valid_i = 1'b0;
        mem_rsp_rdata_i = $urandom;
        check("ld_wb_valid", {31'd0, wb_valid_o}, 32'd1);
        check("ld_wb_we", {31'd0, wb_we_o}, (rd != 0) ? 32'd1 : 32'd0);
        check("ld_wb_rd", {27'd0, wb_rd_o}, {27'd0, rd});
        check("ld_wb_data", wb_data_o, exp_load(f3, a, rdata));
        check("ld_stall", {31'd0, stall_o}, 32'd0);
      end
      $display("[TB] kind=%0d f3=%0d rd=%0d a=0x%08h d=0x%08h rdata=0x%08h", kind, f3, rd, a, d,
               rdata);
    end
    tick();
    check("pulse_end_wb", {31'd0, wb_valid_o}, 32'd0);
    check("pulse_end_redir", {31'd0, redirect_valid_o}, 32'd0);
  endtask

  initial begin
    int kind;
    logic [2:0] f3;
    logic [2:0] ld_f3 [8];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    tick();
    tick();
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_req_valid", {31'd0, mem_req_valid_o}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    check("rst_wb_data", wb_data_o, 32'd0);
    check("rst_redir", {31'd0, redirect_valid_o}, 32'd0);
    check("rst_addr", mem_req_addr_o, 32'd0);
    reset_n = 1'b1;
    tick();

    // Directed cases.
    run_txn(K_OP, 5'd5, 32'h1234, 32'h0, 3'd0, 1'b0, 32'h0, 32'h0, 0, 0);
    run_txn(K_LD, 5'd7, 32'h103, 32'h0, 3'd0, 1'b0, 32'h0, 32'h80FF_FFFF, 1, 0);
    run_txn(K_ST, 5'd0, 32'h202, 32'hABCD, 3'd1, 1'b0, 32'h0, 32'h0, 0, 0);
    run_txn(K_BR, 5'd3, 32'h0, 32'h0, 3'd0, 1'b1, 32'h400, 32'h0, 0, 0);
    run_txn(K_BR, 5'd3, 32'h0, 32'h0, 3'd0, 1'b0, 32'h400, 32'h0, 0, 0);
    run_txn(K_JM, 5'd1, 32'h88, 32'h0, 3'd0, 1'b0, 32'h1000, 32'h0, 0, 0);
    run_txn(K_LD, 5'd9, 32'h101, 32'h0, 3'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 0, 1);

    // Reset while waiting for a load response; the late response is ignored.
    in_valid = 1'b1; instr_ld_i = 1'b1; rd_i = 5'd4; funct3_i = 3'd2; alu_result_i = 32'h40;
    tick();
    in_valid = 1'b0; instr_ld_i = 1'b0;
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    check("rsp_state_stall", {31'd0, stall_o}, 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst_resp_stall", {31'd0, stall_o}, 32'd0);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_rdata_i = 32'h1111_2222;
    tick();
    mem_rsp_valid_i = 1'b0;
    check("late_rsp_wb", {31'd0, wb_valid_o}, 32'd0);
    check("late_rsp_stall", {31'd0, stall_o}, 32'd0);
    check("late_rsp_req", {31'd0, mem_req_valid_o}, 32'd0);
    $display("[TB] reset during RESP, late response dropped");

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 4);
      if (kind == K_LD) f3 = ld_f3[$urandom_range(0, 7)];
      else f3 = 3'($urandom_range(0, 2));
      run_txn(kind, 5'($urandom_range(0, 31)), $urandom, $urandom, f3, 1'($urandom_range(0, 1)),
              $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
Memory/commit stage of the PA-MIRI in-order pipeline. It sits directly downstream of the ALU stage and consumes its outputs: ALU result, zero flag, branch target PC, rd, rs2 data and the decoded ld/st/jm/br/op class flags.
- Loads and stores drive a valid/ready data-memory request port and wait for the load response, stalling upstream.
- Branch and jump redirects are resolved here.
- Results are delivered to writeback.

Parameters:
WD_SIZE, 32, data word width (from PARAMS_pkg)
INSTR_SIZE, 32, PC width
INSTR_REG_BITS, 5, register index width
BE_BITS, WD_SIZE/8, byte-enable width

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
in_valid  in  1  upstream instruction valid
stall_o  out  1  upstream must hold its outputs
pc_i  in  INSTR_SIZE  branch/jump target computed by the ALU stage
rd_i  in  INSTR_REG_BITS  destination register
instr_op_i / instr_ld_i / instr_st_i / instr_jm_i / instr_br_i  in  1 each  class flags (one-hot)
funct3_i  in  3  access size/sign
alu_result_i  in  WD_SIZE  effective address or arithmetic result
alu_zero_i  in  1  branch condition
rs2_data_i  in  WD_SIZE  store data
mem_req_valid_o  out  1  request valid
mem_req_ready_i  in  1  request accepted
mem_req_we_o  out  1  1 = store
mem_req_addr_o  out  WD_SIZE  word-aligned address
mem_req_wdata_o  out  WD_SIZE  lane-replicated store data
mem_req_be_o  out  BE_BITS  byte enables
mem_rsp_valid_i  in  1  load data valid
mem_rsp_rdata_i  in  WD_SIZE  load word
wb_valid_o  out  1  writeback pulse
wb_we_o  out  1  register write enable
wb_rd_o  out  INSTR_REG_BITS  writeback register
wb_data_o  out  WD_SIZE  writeback data
redirect_valid_o  out  1  fetch redirect pulse
redirect_pc_o  out  INSTR_SIZE  redirect target

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE. All outputs 0. Any in-flight request is abandoned; a late mem_rsp_valid_i is ignored.
- FSM states:
  - IDLE: in_valid is sampled only here. stall_o=0.
  - REQ: mem_req_valid_o=1; request fields stay stable until ready.
  - RESP: waiting for load data.
- stall_o = (state != IDLE). It is high from the cycle after a memory op is accepted until the cycle after that op completes.
- IDLE, in_valid, op or jm: next cycle wb_valid_o=1, wb_we_o=(rd_i!=0), wb_data_o=alu_result_i. Latency 1.
- IDLE, in_valid, jm: also pulse redirect_valid_o=1 with redirect_pc_o=pc_i, same cycle as wb.
- IDLE, in_valid, br: next cycle wb_valid_o=1, wb_we_o=0. redirect_valid_o=alu_zero_i, redirect_pc_o=pc_i.
- IDLE, in_valid, ld or st: latch all fields, go to REQ.
  - mem_req_addr_o={alu_result[WD-1:2],2'b00}.
  - be: funct3[1:0]=00 gives 0001<<a[1:0]; 01 gives 0011<<{a[1],1'b0}; 10 gives 1111.
  - wdata: byte replicated x4, half replicated x2, or word.
- REQ with mem_req_ready_i=1:
  - Store: go to IDLE; next cycle wb_valid_o=1, wb_we_o=0. Minimum store latency 2.
  - Load: go to RESP.
- mem_rsp_valid_i while in REQ: protocol violation, ignored.
- RESP with mem_rsp_valid_i=1:
  - Select the lane by the latched a[1:0].
  - Extend: funct3 000 → sign-extend byte; 001 → sign-extend half; 010 → word; 100 → zero-extend byte; 101 → zero-extend half.
  - Next cycle wb_valid_o=1, wb_we_o=(rd!=0); return to IDLE. Minimum load latency 3.
- Ready and response asserted in the same cycle as the request (ready in REQ, response before RESP) are not supported; the response must arrive at least 1 cycle after the handshake.
- wb_valid_o and redirect_valid_o are single-cycle registered pulses.
- Undefined funct3 is treated as word.

Optional Feature:
Macro MEM_MISALIGN_TRAP_EN.
- Defined: half access with a[0]!=0, or word access with a[1:0]!=0, issues no request. Next cycle wb_valid_o=1, wb_we_o=0, and extra ports misalign_o=1 (pulse) and misalign_addr_o=alu_result_i.
- Undefined: those ports do not exist. Low address bits below the access size are ignored and the access proceeds on the aligned lanes.

Decomposition:
PARAMS_pkg adds:
- mem_state_t enum {MEM_IDLE, MEM_REQ, MEM_RESP}.
- FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW constants.
- BE_BITS.

One combinational sub-module, load_align: takes rdata, a[1:0] and funct3, and returns the extended word.

Test Plan:
1. op, rd=5, alu_result=0x1234 → 1 cycle later wb_valid=1, we=1, rd=5, data=0x1234; stall_o never asserts.
2. LB at 0x103, rsp 0x80FFFFFF, ready held 2 cycles → be=1000; wb_data=0xFFFFFF80 3 cycles after ready; stall_o high throughout.
3. SH at 0x202, rs2=0xABCD → be=1100, wdata=0xABCDABCD, we=1; wb_we=0 the cycle after ready.
4. br with zero=1, pc_i=0x400 → redirect_valid pulse, redirect_pc=0x400, wb_we=0. With zero=0: no redirect.
5. Reset asserted in RESP, then rsp_valid arrives → no wb_valid, state IDLE, stall_o=0.
6. With MEM_MISALIGN_TRAP_EN: LW at 0x101 → mem_req_valid never asserts; misalign_o=1, misalign_addr_o=0x101.
